// File: rtl/rv_pkg.sv
// Shared RISC-V datapath definitions.
// Holds the opcode constants, the data-memory responder state type and the datapath width.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with a synchronous write and a registered, enable-gated read.
// The array has no reset; the read register keeps its value until the next read.
module dmem_array
  import rv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [XLEN-1:0]                wdata,
  output logic [XLEN-1:0]                rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load or store from the datapath, inserts
// WAIT_STATES idle cycles, performs the array access and holds stall until it is done.
module dmem_responder
  import rv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Memread,
  input  logic            Memwrite,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two, at least 4");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_STATES must be in 0..15");
  end

  dmem_state_t     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            write_q, write_d;
  logic            illegal_q, illegal_d;
  logic            rvalid_q, rvalid_d;

  logic            req;
  logic            ram_we;
  logic            ram_re;
  logic [XLEN-1:0] ram_rdata;
  logic            unused_addr_bits;

  // Upper address bits only select an alias of the same word, so they are dropped.
  assign unused_addr_bits = ^addr[XLEN-1:AW+2];
  assign req = Memread | Memwrite;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      illegal_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      illegal_q <= illegal_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    illegal_d = illegal_q;
    rvalid_d  = rvalid_q;
    stall     = 1'b0;
    err       = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          idx_d     = addr[AW+1:2];
          wdata_d   = wdata;
          write_d   = Memwrite;
          illegal_d = (addr[1:0] != 2'b00) || (Memread && Memwrite);
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WS;
          end else begin
            state_d = ACCESS;
          end
        end
      end

      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ACCESS;
        end
      end

      // An illegal access never touches the array and forces rdata to zero.
      ACCESS: begin
        stall   = 1'b1;
        state_d = DONE;
        if (illegal_q) begin
          rvalid_d = 1'b0;
        end else if (write_q) begin
          ram_we = !rst;
        end else begin
          ram_re   = 1'b1;
          rvalid_d = 1'b1;
        end
      end

      DONE: begin
        err     = illegal_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .idx  (idx_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // The array read register is not reset, so rdata is masked until a legal load lands.
  assign rdata = rvalid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (2 and 0 wait states) driven by
// directed and random loads/stores, checked by per-instance monitors against a memory model.
module tb_dmem_responder;

  localparam int WS0 = 2;
  localparam int DEPTH0 = 256;
  localparam int WS1 = 0;
  localparam int DEPTH1 = 16;

  typedef struct {
    bit          chk;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, mr0, mr1, mw0, mw1;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1;
  logic        stall0, stall1, err0, err1;

  exp_t q0[$];
  exp_t q1[$];
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_m   [2][256];
  bit          known_m [2][256];
  logic [31:0] last_rd [2];
  bit          last_known [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst(rst0), .Memread(mr0), .Memwrite(mw0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .stall(stall0), .err(err0));

  dmem_responder #(.DEPTH_WORDS(DEPTH1), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst(rst1), .Memread(mr1), .Memwrite(mw1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .stall(stall1), .err(err1));

  function automatic int wsOf(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic int depthOf(input int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic logic getStall(input int d);
    return (d == 0) ? stall0 : stall1;
  endfunction

  function automatic logic getErr(input int d);
    return (d == 0) ? err0 : err1;
  endfunction

  function automatic logic getRst(input int d);
    return (d == 0) ? rst0 : rst1;
  endfunction

  function automatic logic [31:0] getRdata(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  task automatic driveInputs(input int d, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      mr0 = rd; mw0 = wr; addr0 = a; wdata0 = wd;
    end else begin
      mr1 = rd; mw1 = wr; addr1 = a; wdata1 = wd;
    end
  endtask

  task automatic setRst(input int d, input logic v);
    if (d == 0) rst0 = v;
    else rst1 = v;
  endtask

  task automatic check32(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input int d, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d: got %b expected %b at %0t", name, d, act, exp, $time);
    end
  endtask

  // Issue one request in an IDLE cycle, record its expected outcome, then wait for DONE.
  task automatic applyStimulus(input int d, input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, input bit scramble);
    exp_t e;
    bit   illegal;
    int   idx;
    bit   done;
    @(negedge clk);
    driveInputs(d, rd, wr, a, wd);
    @(posedge clk);
    illegal = (a % 4 != 0) || (rd && wr);
    idx = int'((a / 4) % 32'(depthOf(d)));
    if (illegal) begin
      last_rd[d] = 32'h0;
      last_known[d] = 1'b1;
    end else if (wr) begin
      mem_m[d][idx] = wd;
      known_m[d][idx] = 1'b1;
    end else begin
      last_rd[d] = mem_m[d][idx];
      last_known[d] = known_m[d][idx];
    end
    e.chk = last_known[d];
    e.rdata = last_rd[d];
    e.err = illegal;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (scramble) driveInputs(d, 1'($urandom), 1'($urandom), $urandom, $urandom);
      else driveInputs(d, 1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      if (!getStall(d)) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout dut%0d: got stall stuck expected release in 40 cycles", d);
    end
    driveInputs(d, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Start a store, then assert reset while it is still waiting; it must never be written.
  task automatic applyAbortedStore(input int d, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    driveInputs(d, 1'b0, 1'b1, a, wd);
    @(posedge clk);
    @(negedge clk);
    driveInputs(d, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    setRst(d, 1'b1);
    #1;
    check1("stall_on_reset", d, getStall(d), 1'b0);
    check32("rdata_on_reset", d, getRdata(d), 32'h0);
    check1("err_on_reset", d, getErr(d), 1'b0);
    last_rd[d] = 32'h0;
    last_known[d] = 1'b1;
    repeat (2) @(negedge clk);
    setRst(d, 1'b0);
  endtask

  task automatic randomOps(input int d, input int n);
    int r;
    bit rd, wr;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      rd = (r < 50);
      wr = (r >= 45);
      a = 32'($urandom_range(0, 3)) * 32'(depthOf(d) * 4) + 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      applyStimulus(d, rd, wr, a, $urandom, 1'($urandom));
    end
  endtask

  // Monitor: a falling stall after a busy run marks DONE, where the queued outcome is due.
  task automatic checkOutput(input int d);
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      #1;
      if (getRst(d)) begin
        run = 0;
        if (d == 0) q0.delete();
        else q1.delete();
        check1("stall_in_reset", d, getStall(d), 1'b0);
        continue;
      end
      if (getStall(d)) begin
        run++;
        check1("err_while_busy", d, getErr(d), 1'b0);
      end else if (run > 0) begin
        vectors++;
        if (run != wsOf(d) + 2) begin
          miscompares++;
          $display("[TB] FAIL stall_cycles dut%0d: got %0d expected %0d", d, run, wsOf(d) + 2);
        end
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_done dut%0d: got completion expected none", d);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check1("err_done", d, getErr(d), e.err);
          if (e.chk) check32("rdata_done", d, getRdata(d), e.rdata);
        end
        run = 0;
      end else begin
        check1("err_idle", d, getErr(d), 1'b0);
        if (last_known[d]) check32("rdata_hold", d, getRdata(d), last_rd[d]);
      end
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    driveInputs(0, 1'b0, 1'b0, 32'h0, 32'h0);
    driveInputs(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = 32'h0;
      last_known[d] = 1'b1;
      for (int i = 0; i < 256; i++) known_m[d][i] = 1'b0;
    end
    fork
      checkOutput(0);
      checkOutput(1);
    join_none
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check1("reset_stall", d, getStall(d), 1'b0);
      check32("reset_rdata", d, getRdata(d), 32'h0);
      check1("reset_err", d, getErr(d), 1'b0);
    end
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;

    $display("[TB] directed sequence, 2 wait states");
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0010, 32'h1111_0000, 1'b0);
    applyAbortedStore(0, 32'h0000_0010, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0001, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
    randomOps(0, 80);

    $display("[TB] directed sequence, 0 wait states");
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b1);
    randomOps(1, 80);

    repeat (4) @(negedge clk);
    check32("queue0_drained", 0, 32'(q0.size()), 32'h0);
    check32("queue1_drained", 1, 32'(q1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
